clken_ctrl: RTL and testbench

- Multi-channel clock-enable controller and scheduler.
- Holds per-channel configuration (divide ratio, mode, pulse count) and sequences start, stop and restart of each channel's divider.
- Produces single-cycle clken pulses for downstream slow logic (UART bit timing, LED/PWM scanning, sampling strobes), plus busy/done status.
- Sits between a control master (CPU/FSM register writes) and the blocks consuming clock enables.

---
 rtl/clken_ctrl.sv | 135 +++++++++++++
 tb/tb_clken_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clken_ctrl.sv
// Multi-channel clock-enable scheduler: per-channel shadow config, IDLE/RUN sequencing,
// registered single-cycle clken pulses, with busy and burst-done status.
module clken_ctrl #(
   parameter int NCH     = 4,
   parameter int CW      = 8,
   parameter int DIV_RST = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_wr,
   input  logic [2:0]     cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   input  logic [CW-1:0]  cfg_cnt,
   input  logic           cfg_mode,
   input  logic [NCH-1:0] start,
   input  logic [NCH-1:0] stop,
   output logic [NCH-1:0] clken,
   output logic [NCH-1:0] busy,
   output logic [NCH-1:0] done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        st_q   [NCH];
   state_t        st_d   [NCH];
   logic [CW-1:0] sh_div_q [NCH];
   logic [CW-1:0] sh_cnt_q [NCH];
   logic          sh_mode_q[NCH];
   logic [CW-1:0] div_q  [NCH];
   logic [CW-1:0] div_d  [NCH];
   logic [CW-1:0] ctr_q  [NCH];
   logic [CW-1:0] ctr_d  [NCH];
   logic [CW-1:0] left_q [NCH];
   logic [CW-1:0] left_d [NCH];
   logic          mode_q [NCH];
   logic          mode_d [NCH];
   logic [NCH-1:0] clken_q, clken_d;
   logic [NCH-1:0] done_q, done_d;
   logic [NCH-1:0] go;

   // Channel numbers >= NCH never match the loop index, so such writes fall on the floor.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            sh_div_q[i]  <= CW'(DIV_RST);
            sh_cnt_q[i]  <= CW'(1);
            sh_mode_q[i] <= 1'b0;
         end
      end else if (cfg_wr) begin
         for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == 3'(i)) begin
               sh_div_q[i]  <= cfg_div;
               sh_cnt_q[i]  <= cfg_cnt;
               sh_mode_q[i] <= cfg_mode;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]   <= IDLE;
            div_q[i]  <= '0;
            ctr_q[i]  <= '0;
            left_q[i] <= '0;
            mode_q[i] <= 1'b0;
         end
         clken_q <= '0;
         done_q  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]   <= st_d[i];
            div_q[i]  <= div_d[i];
            ctr_q[i]  <= ctr_d[i];
            left_q[i] <= left_d[i];
            mode_q[i] <= mode_d[i];
         end
         clken_q <= clken_d;
         done_q  <= done_d;
      end
   end

   // A start is honoured unless stop is also present or it is a zero-length burst.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         go[i] = start[i] && !stop[i] && !(sh_mode_q[i] && (sh_cnt_q[i] == '0));
      end
   end

   always_comb begin
      clken_d = '0;
      done_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         st_d[i]   = st_q[i];
         div_d[i]  = div_q[i];
         ctr_d[i]  = ctr_q[i];
         left_d[i] = left_q[i];
         mode_d[i] = mode_q[i];
         if ((st_q[i] == RUN) && stop[i]) begin
            st_d[i] = IDLE;
         end else if (go[i]) begin
            st_d[i]   = RUN;
            div_d[i]  = sh_div_q[i];
            mode_d[i] = sh_mode_q[i];
            left_d[i] = sh_cnt_q[i];
            ctr_d[i]  = '0;
         end else if (st_q[i] == RUN) begin
            if (ctr_q[i] == div_q[i]) begin
               ctr_d[i]   = '0;
               clken_d[i] = 1'b1;
               if (mode_q[i]) begin
                  left_d[i] = left_q[i] - 1'b1;
                  if (left_q[i] == CW'(1)) begin
                     done_d[i] = 1'b1;
                     st_d[i]   = IDLE;
                  end
               end
            end else begin
               ctr_d[i] = ctr_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         busy[i] = (st_q[i] == RUN);
      end
   end

   assign clken = clken_q;
   assign done  = done_q;

endmodule

// File: tb/tb_clken_ctrl.sv
// Directed self-checking bench for clken_ctrl with hand-computed pulse timing.
module tb_clken_ctrl;

   logic       clk;
   logic       rst;
   logic       cfg_wr;
   logic [2:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [7:0] cfg_cnt;
   logic       cfg_mode;
   logic [3:0] start;
   logic [3:0] stop;
   logic [3:0] clken;
   logic [3:0] busy;
   logic [3:0] done;

   int total = 0;
   int bad   = 0;

   clken_ctrl #(.NCH(4), .CW(8), .DIV_RST(16)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_cnt(cfg_cnt), .cfg_mode(cfg_mode), .start(start), .stop(stop),
      .clken(clken), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cfg(input logic [2:0] ch, input logic [7:0] dv, input logic [7:0] cn,
                         input logic md);
      cfg_wr = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_cnt = cn; cfg_mode = md;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] m);
      start = m;
      tick();
      start = '0;
   endtask

   task automatic do_stop(input logic [3:0] m);
      stop = m;
      tick();
      stop = '0;
   endtask

   initial begin
      int np;
      rst = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_cnt = '0;
      cfg_mode = 1'b0; start = '0; stop = '0;
      #12;
      chk("rst_clken", int'(clken), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b1;
      tick();

      // default shadow on ch0: free-run, period 17
      do_start(4'b0001);
      chk("t1_busy_e0", int'(busy[0]), 1);
      for (int k = 1; k <= 52; k++) begin
         tick();
         chk("t1_clken", int'(clken[0]), int'(k % 17 == 0));
         chk("t1_busy", int'(busy[0]), 1);
         chk("t1_done", int'(done[0]), 0);
      end
      do_stop(4'b0001);
      chk("t1_stop_busy", int'(busy[0]), 0);
      chk("t1_stop_clken", int'(clken[0]), 0);

      // ch1 burst of 5, period 4
      wr_cfg(3'd1, 8'd3, 8'd5, 1'b1);
      do_start(4'b0010);
      chk("t2_busy_e0", int'(busy[1]), 1);
      np = 0;
      for (int k = 1; k <= 28; k++) begin
         tick();
         np += int'(clken[1]);
         chk("t2_clken", int'(clken[1]), int'((k % 4 == 0) && (k <= 20)));
         chk("t2_done", int'(done[1]), int'(k == 20));
         chk("t2_busy", int'(busy[1]), int'(k < 20));
      end
      chk("t2_npulses", np, 5);

      // ch2 div=0 free-run, stop after 10 cycles
      wr_cfg(3'd2, 8'd0, 8'd9, 1'b0);
      do_start(4'b0100);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t3_clken", int'(clken[2]), 1);
      end
      do_stop(4'b0100);
      chk("t3_stop_clken", int'(clken[2]), 0);
      chk("t3_stop_busy", int'(busy[2]), 0);
      chk("t3_stop_done", int'(done[2]), 0);
      tick();
      chk("t3_after_clken", int'(clken[2]), 0);

      // shadow write to running ch0 has no effect until restart
      do_start(4'b0001);
      for (int k = 1; k <= 34; k++) begin
         if (k == 6) begin
            wr_cfg(3'd0, 8'd2, 8'd1, 1'b0);
         end else begin
            tick();
         end
         chk("t4_old_period", int'(clken[0]), int'(k % 17 == 0));
      end
      do_start(4'b0001);
      chk("t4_restart_clken", int'(clken[0]), 0);
      chk("t4_restart_busy", int'(busy[0]), 1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("t4_new_period", int'(clken[0]), int'(k % 3 == 0));
      end
      do_stop(4'b0001);

      // same-cycle start+stop on idle ch3: stop wins
      start = 4'b1000; stop = 4'b1000;
      tick();
      start = '0; stop = '0;
      chk("t4_ss_busy", int'(busy[3]), 0);
      tick();
      chk("t4_ss_clken", int'(clken[3]), 0);

      // start with same-cycle cfg write: old shadow (div=16) is used
      cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd1; cfg_cnt = 8'd1; cfg_mode = 1'b0;
      start = 4'b1000;
      tick();
      cfg_wr = 1'b0; start = '0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("t4_prewr_clken", int'(clken[3]), int'(k == 17));
      end
      do_stop(4'b1000);

      // burst with cnt=0 is ignored
      wr_cfg(3'd1, 8'd2, 8'd0, 1'b1);
      do_start(4'b0010);
      for (int k = 1; k <= 5; k++) begin
         chk("t5_c0_busy", int'(busy[1]), 0);
         chk("t5_c0_clken", int'(clken[1]), 0);
         chk("t5_c0_done", int'(done[1]), 0);
         tick();
      end
      // write to nonexistent channel 5 must not touch ch1 (5 aliases to 1 in 2 bits)
      wr_cfg(3'd5, 8'd1, 8'd3, 1'b1);
      do_start(4'b0010);
      chk("t5_ch5_busy", int'(busy[1]), 0);
      tick();
      chk("t5_ch5_clken", int'(clken[1]), 0);

      // async reset mid-burst
      wr_cfg(3'd1, 8'd3, 8'd5, 1'b1);
      do_start(4'b0010);
      for (int k = 1; k <= 8; k++) tick();
      chk("t6_pre_clken", int'(clken[1]), 1);
      chk("t6_pre_busy", int'(busy[1]), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_clken", int'(clken), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_done", int'(done), 0);
      #4;
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("t6_idle_busy", int'(busy[1]), 0);
         chk("t6_idle_done", int'(done[1]), 0);
         chk("t6_idle_clken", int'(clken[1]), 0);
      end
      do_start(4'b0010);
      for (int k = 1; k <= 34; k++) begin
         tick();
         chk("t6_def_clken", int'(clken[1]), int'(k % 17 == 0));
         chk("t6_def_busy", int'(busy[1]), 1);
         chk("t6_def_done", int'(done[1]), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
